// File: rtl/seq_shift_unit_if.sv
// seq_shift_unit_if: start/ready request channel and result channel of seq_shift_unit.
// The master drives the request. The slave is the shift unit.
interface seq_shift_unit_if #(
    parameter int unsigned WIDTH = 32
);
    logic             start;
    logic [WIDTH-1:0] X;
    logic [WIDTH-1:0] Y;
    logic [1:0]       mode;
    logic             ready;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] Z;

    modport master (
        output start, X, Y, mode,
        input  ready, busy, done, Z
    );

    modport slave (
        input  start, X, Y, mode,
        output ready, busy, done, Z
    );
endinterface

// File: rtl/seq_shift_unit.sv
// seq_shift_unit: multi-cycle shifter supporting SRL, SRA, SLL and ROR.
// Each clock shifts the result register by up to STEP bit positions.
// Define SEQ_SHIFT_ROTATE_EN to compile the rotate path. Without it, mode 11
// returns the operand unchanged after a zero-length operation.
module seq_shift_unit #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned STEP  = 1
) (
    input  logic clk,
    input  logic rst_n,
    seq_shift_unit_if.slave sh
);
    localparam int unsigned LW = $clog2(WIDTH);
    localparam int unsigned CW = $clog2(WIDTH + 1);
    localparam int unsigned SW = $clog2(STEP + 1);

    localparam logic [1:0] M_SRL = 2'b00;
    localparam logic [1:0] M_SRA = 2'b01;
    localparam logic [1:0] M_SLL = 2'b10;
    localparam logic [1:0] M_ROR = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t           r_state;
    logic [WIDTH-1:0] r_z;
    logic [CW-1:0]    r_rem;
    logic [1:0]       r_mode;
    logic             r_sign;
    logic             r_ready;
    logic             r_busy;
    logic             r_done;

    logic [CW-1:0]    w_amt;
    logic [SW-1:0]    w_s;
    logic [WIDTH-1:0] w_fill;
    logic [WIDTH-1:0] w_shifted;

    // Effective amount of a new request: saturate shifts at WIDTH, wrap rotates
    always_comb begin
        w_amt = (|sh.Y[WIDTH-1:LW]) ? CW'(WIDTH) : CW'(sh.Y[LW-1:0]);
        if (sh.mode == M_ROR) begin
`ifdef SEQ_SHIFT_ROTATE_EN
            w_amt = CW'(sh.Y[LW-1:0]);
`else
            w_amt = '0;
`endif
        end
    end

    // One shift step of at most STEP positions applied to the result register
    always_comb begin
        w_s       = (r_rem < CW'(STEP)) ? SW'(r_rem) : SW'(STEP);
        w_fill    = ~({WIDTH{1'b1}} >> w_s);
        w_shifted = r_z;
        case (r_mode)
            M_SRL:   w_shifted = r_z >> w_s;
            M_SRA:   w_shifted = (r_z >> w_s) | (r_sign ? w_fill : '0);
            M_SLL:   w_shifted = r_z << w_s;
`ifdef SEQ_SHIFT_ROTATE_EN
            M_ROR:   w_shifted = (r_z >> w_s) | (r_z << (CW'(WIDTH) - CW'(w_s)));
`endif
            default: w_shifted = r_z;
        endcase
    end

    // Control FSM with registered handshake outputs and the datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_z     <= '0;
            r_rem   <= '0;
            r_mode  <= M_SRL;
            r_sign  <= 1'b0;
            r_ready <= 1'b1;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (sh.start) begin
                        r_z     <= sh.X;
                        r_mode  <= sh.mode;
                        r_sign  <= sh.X[WIDTH-1];
                        r_rem   <= w_amt;
                        r_ready <= 1'b0;
                        r_busy  <= 1'b1;
                        if (w_amt == '0) begin
                            r_state <= S_DONE;
                            r_done  <= 1'b1;
                        end else begin
                            r_state <= S_SHIFT;
                        end
                    end
                end
                S_SHIFT: begin
                    r_z   <= w_shifted;
                    r_rem <= r_rem - CW'(w_s);
                    if (r_rem == CW'(w_s)) begin
                        r_state <= S_DONE;
                        r_done  <= 1'b1;
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_ready <= 1'b1;
                end
                default: begin
                    r_state <= S_IDLE;
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_ready <= 1'b1;
                end
            endcase
        end
    end

    assign sh.ready = r_ready;
    assign sh.busy  = r_busy;
    assign sh.done  = r_done;
    assign sh.Z     = r_z;
endmodule
